// File: rtl/display_scheduler_if.sv
// Bundle between the display requesters and the scheduler: request/data in,
// ownership and the selected display word out.
interface display_scheduler_if #(
    parameter int NREQ = 3
);
    logic [NREQ-1:0]    req;
    logic [16*NREQ-1:0] data;
    logic [NREQ-1:0]    grant;
    logic [1:0]         owner;
    logic [15:0]        num;
    logic               num_valid;

    modport master (
        output req, data,
        input  grant, owner, num, num_valid
    );

    modport slave (
        input  req, data,
        output grant, owner, num, num_valid
    );
endinterface

// File: rtl/display_scheduler.sv
// Round-robin owner of the 7-segment display word with a minimum hold time
// per owner; an owner that drops its request gives the display up at once.
module display_scheduler #(
    parameter int          NREQ       = 3,
    parameter int          HOLD       = 50000000,
    parameter logic [15:0] IDLE_VALUE = 16'h0000
) (
    input  logic               clk,
    input  logic               rst,
    display_scheduler_if.slave bus
);
    localparam int HW = $clog2(HOLD);

    typedef enum logic {IDLE, SHOW} state_t;

    state_t          state, nxt_state;
    logic [NREQ-1:0] grant_q, nxt_grant;
    logic [1:0]      owner_q, nxt_owner;
    logic [1:0]      ptr_q, nxt_ptr;
    logic [15:0]     num_q, nxt_num;
    logic            valid_q, nxt_valid;
    logic [HW-1:0]   hold_q, nxt_hold;

    logic [1:0]      winner;
    logic [1:0]      idx;
    logic            found;
    logic            own_req;
    logic            other_req;
    logic            take;

    // Scan starts just after the last winner, so in SHOW the owner is checked last.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = 2'((int'(ptr_q) + i) % NREQ);
            if (!found && bus.req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    assign own_req   = |(bus.req & grant_q);
    assign other_req = |(bus.req & ~grant_q);

    always_comb begin
        nxt_state = state;
        nxt_grant = grant_q;
        nxt_owner = owner_q;
        nxt_ptr   = ptr_q;
        nxt_valid = valid_q;
        nxt_hold  = hold_q;
        take      = 1'b0;

        case (state)
            IDLE: begin
                if (found) begin
                    take = 1'b1;
                end
            end
            SHOW: begin
                if (!own_req && other_req) begin
                    take = 1'b1;
                end else if (!own_req) begin
                    nxt_state = IDLE;
                    nxt_grant = '0;
                    nxt_owner = '0;
                    nxt_valid = 1'b0;
                    nxt_hold  = '0;
                end else if (hold_q == HW'(HOLD - 1) && other_req) begin
                    take = 1'b1;
                end else if (hold_q != HW'(HOLD - 1)) begin
                    nxt_hold = hold_q + 1'b1;
                end
            end
            default: begin
                nxt_state = IDLE;
            end
        endcase

        if (take) begin
            nxt_state = SHOW;
            nxt_grant = NREQ'(1) << winner;
            nxt_owner = winner;
            nxt_ptr   = winner;
            nxt_valid = 1'b1;
            nxt_hold  = '0;
        end

        nxt_num = nxt_valid ? bus.data[int'(nxt_owner) * 16 +: 16] : IDLE_VALUE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            grant_q <= '0;
            owner_q <= '0;
            ptr_q   <= 2'(NREQ - 1);
            num_q   <= IDLE_VALUE;
            valid_q <= 1'b0;
            hold_q  <= '0;
        end else begin
            state   <= nxt_state;
            grant_q <= nxt_grant;
            owner_q <= nxt_owner;
            ptr_q   <= nxt_ptr;
            num_q   <= nxt_num;
            valid_q <= nxt_valid;
            hold_q  <= nxt_hold;
        end
    end

    assign bus.grant     = grant_q;
    assign bus.owner     = owner_q;
    assign bus.num       = num_q;
    assign bus.num_valid = valid_q;
endmodule

// File: tb/tb_display_scheduler.sv
// Table-driven scoreboard bench for display_scheduler with NREQ=3, HOLD=4.
module tb_display_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b0;

    display_scheduler_if #(.NREQ(3)) bus ();

    display_scheduler #(
        .NREQ(3),
        .HOLD(4),
        .IDLE_VALUE(16'h0000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  req;
        logic [15:0] d0;
        logic [15:0] d1;
        logic [15:0] d2;
        logic [2:0]  grant;
        logic [1:0]  owner;
        logic [15:0] num;
        logic        valid;
    } vec_t;

    typedef struct {
        logic [2:0]  grant;
        logic [1:0]  owner;
        logic [15:0] num;
        logic        valid;
    } exp_t;

    vec_t phase_a[$];
    vec_t phase_b[$];
    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    function automatic vec_t mk(logic [2:0] req, logic [15:0] d0, logic [15:0] d1,
                                logic [15:0] d2, logic [2:0] grant, logic [1:0] owner,
                                logic [15:0] num, logic valid);
        vec_t v;
        v.req   = req;
        v.d0    = d0;
        v.d1    = d1;
        v.d2    = d2;
        v.grant = grant;
        v.owner = owner;
        v.num   = num;
        v.valid = valid;
        return v;
    endfunction

    task automatic checkValue(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL %s scoreboard: got empty queue, expected an entry", tag);
            return;
        end
        e = sb.pop_front();
        checkValue({tag, ".grant"}, 16'(bus.grant), 16'(e.grant));
        checkValue({tag, ".owner"}, 16'(bus.owner), 16'(e.owner));
        checkValue({tag, ".num"}, bus.num, e.num);
        checkValue({tag, ".valid"}, 16'(bus.num_valid), 16'(e.valid));
    endtask

    task automatic applyStimulus(input vec_t v, input string tag);
        exp_t e;
        bus.req  = v.req;
        bus.data = {v.d2, v.d1, v.d0};
        e.grant  = v.grant;
        e.owner  = v.owner;
        e.num    = v.num;
        e.valid  = v.valid;
        sb.push_back(e);
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    initial begin
        // Single requester, data tracking, release to idle; then a lone owner for 20 cycles.
        phase_a.push_back(mk(3'b001, 16'h1234, 16'h0000, 16'h0000, 3'b001, 2'd0, 16'h1234, 1'b1));
        phase_a.push_back(mk(3'b001, 16'hABCD, 16'h0000, 16'h0000, 3'b001, 2'd0, 16'hABCD, 1'b1));
        phase_a.push_back(mk(3'b000, 16'hABCD, 16'h0000, 16'h0000, 3'b000, 2'd0, 16'h0000, 1'b0));
        for (int i = 0; i < 20; i++) begin
            phase_a.push_back(mk(3'b010, 16'hDEAD, 16'(16'h5000 + i), 16'hBEEF,
                                 3'b010, 2'd1, 16'(16'h5000 + i), 1'b1));
        end
        phase_a.push_back(mk(3'b000, 16'hDEAD, 16'h5555, 16'hBEEF, 3'b000, 2'd0, 16'h0000, 1'b0));

        // Full contention rotation, early release of owner 0, then wrap from owner 2 to 0.
        for (int i = 0; i < 4; i++)
            phase_b.push_back(mk(3'b111, 16'h1111, 16'h2222, 16'h3333, 3'b001, 2'd0, 16'h1111, 1'b1));
        for (int i = 0; i < 4; i++)
            phase_b.push_back(mk(3'b111, 16'h1111, 16'h2222, 16'h3333, 3'b010, 2'd1, 16'h2222, 1'b1));
        for (int i = 0; i < 4; i++)
            phase_b.push_back(mk(3'b111, 16'h1111, 16'h2222, 16'h3333, 3'b100, 2'd2, 16'h3333, 1'b1));
        phase_b.push_back(mk(3'b111, 16'h1111, 16'h2222, 16'h3333, 3'b001, 2'd0, 16'h1111, 1'b1));
        phase_b.push_back(mk(3'b111, 16'h1111, 16'h2222, 16'h3333, 3'b001, 2'd0, 16'h1111, 1'b1));
        for (int i = 0; i < 4; i++)
            phase_b.push_back(mk(3'b110, 16'h1111, 16'h2222, 16'h3333, 3'b010, 2'd1, 16'h2222, 1'b1));
        phase_b.push_back(mk(3'b110, 16'h1111, 16'h2222, 16'h3333, 3'b100, 2'd2, 16'h3333, 1'b1));
        for (int i = 0; i < 3; i++)
            phase_b.push_back(mk(3'b111, 16'h1111, 16'h2222, 16'h3333, 3'b100, 2'd2, 16'h3333, 1'b1));
        phase_b.push_back(mk(3'b111, 16'h1111, 16'h2222, 16'h3333, 3'b001, 2'd0, 16'h1111, 1'b1));
        phase_b.push_back(mk(3'b000, 16'h1111, 16'h2222, 16'h3333, 3'b000, 2'd0, 16'h0000, 1'b0));

        bus.req  = '0;
        bus.data = '0;
        repeat (2) @(posedge clk);
        #1;
        checkValue("reset.grant", 16'(bus.grant), 16'h0000);
        checkValue("reset.owner", 16'(bus.owner), 16'h0000);
        checkValue("reset.num", bus.num, 16'h0000);
        checkValue("reset.valid", 16'(bus.num_valid), 16'h0000);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < phase_a.size(); i++)
            applyStimulus(phase_a[i], $sformatf("A%0d", i));

        // Asynchronous reset while owner 2 is showing, checked before any clock edge.
        applyStimulus(mk(3'b100, 16'h0000, 16'h0000, 16'h7777, 3'b100, 2'd2, 16'h7777, 1'b1), "pre_rst0");
        applyStimulus(mk(3'b100, 16'h0000, 16'h0000, 16'h7778, 3'b100, 2'd2, 16'h7778, 1'b1), "pre_rst1");
        #3;
        rst = 1'b0;
        #1;
        checkValue("async_rst.grant", 16'(bus.grant), 16'h0000);
        checkValue("async_rst.owner", 16'(bus.owner), 16'h0000);
        checkValue("async_rst.num", bus.num, 16'h0000);
        checkValue("async_rst.valid", 16'(bus.num_valid), 16'h0000);
        bus.req = '0;
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < phase_b.size(); i++)
            applyStimulus(phase_b[i], $sformatf("B%0d", i));

        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL scoreboard_drain: got %0d leftover, expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
